// File: rtl/regpair_writer.sv
// Purpose : sequences a 16-bit register-pair update into the regfile's 8-bit write port (low byte, then high byte).
// Latency : accept at edge N, low byte written at edge N+1, high byte at edge N+2, done high during cycle N+2..N+3.
// Backpressure: req_ready is high only in IDLE; req_valid is ignored while a write pair is in flight.
//
// Ports:
//   clk, rst            - clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready - request handshake; req_op/req_src/req_dst/req_data describe the update
//   rdwn/rdw            - combinational pair read (select = req_src, data = {high, low})
//   wrn/wr/we           - registered byte write port into the regfile
//   done/flag_h/flag_c  - one-cycle completion pulse with ADD SP,e8 style H/C flags
module regpair_writer (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [1:0]  req_src,
    input  logic [1:0]  req_dst,
    input  logic [15:0] req_data,
    output logic [1:0]  rdwn,
    input  logic [15:0] rdw,
    output logic [2:0]  wrn,
    output logic [7:0]  wr,
    output logic        we,
    output logic        done,
    output logic        flag_h,
    output logic        flag_c
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_ADDS = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WR_LO = 2'b01,
        WR_HI = 2'b10
    } state_t;

    state_t      state_q;
    logic [7:0]  res_hi_q;   // only the high byte must survive past the accept cycle
    logic [1:0]  dst_q;

    logic [15:0] result_d;
    logic        h_d;
    logic        c_d;
    logic [15:0] ofs_sext;
    logic [4:0]  nib_sum;
    logic [8:0]  byte_sum;

    // The pair read is purely combinational so the result is formed in the accept cycle.
    assign rdwn      = req_src;
    assign req_ready = (state_q == IDLE);

    // Flags come from an unsigned add of the low byte, independent of the offset's sign.
    assign ofs_sext = {{8{req_data[7]}}, req_data[7:0]};
    assign nib_sum  = {1'b0, rdw[3:0]} + {1'b0, req_data[3:0]};
    assign byte_sum = {1'b0, rdw[7:0]} + {1'b0, req_data[7:0]};

    always_comb begin
        result_d = req_data;
        h_d      = 1'b0;
        c_d      = 1'b0;
        case (req_op)
            OP_LOAD: result_d = req_data;
            OP_INC:  result_d = rdw + 16'h0001;
            OP_DEC:  result_d = rdw - 16'h0001;
            OP_ADDS: begin
                result_d = rdw + ofs_sext;
                h_d      = nib_sum[4];
                c_d      = byte_sum[8];
            end
            default: result_d = req_data;
        endcase
    end

    // Single registered FSM; all regfile-facing outputs come straight from flops.
    // In the accept cycle the low-byte write is already set up, so WR_LO needs no extra cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            res_hi_q <= 8'h00;
            dst_q    <= 2'b00;
            we       <= 1'b0;
            wrn      <= 3'b000;
            wr       <= 8'h00;
            done     <= 1'b0;
            flag_h   <= 1'b0;
            flag_c   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // done lasts exactly one IDLE cycle; an accept here starts the next request
                    done <= 1'b0;
                    if (req_valid) begin
                        res_hi_q <= result_d[15:8];
                        dst_q    <= req_dst;
                        flag_h   <= h_d;
                        flag_c   <= c_d;
                        we       <= 1'b1;
                        wrn      <= {req_dst, 1'b1};
                        wr       <= result_d[7:0];
                        state_q  <= WR_LO;
                    end
                end
                WR_LO: begin
                    wrn     <= {dst_q, 1'b0};
                    wr      <= res_hi_q;
                    state_q <= WR_HI;
                end
                WR_HI: begin
                    // wrn/wr keep their last value; only the enable drops
                    we      <= 1'b0;
                    done    <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    we      <= 1'b0;
                    done    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regpair_writer.sv
module tb_regpair_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [1:0]  req_src;
    logic [1:0]  req_dst;
    logic [15:0] req_data;
    logic [1:0]  rdwn;
    logic [15:0] rdw;
    logic [2:0]  wrn;
    logic [7:0]  wr;
    logic        we;
    logic        done;
    logic        flag_h;
    logic        flag_c;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [1:0] BC = 2'd0, DE = 2'd1, HL = 2'd2, SP = 2'd3;
    localparam logic [1:0] LOAD = 2'b00, INC = 2'b01, DEC = 2'b10, ADDS = 2'b11;

    regpair_writer dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_src   (req_src),
        .req_dst   (req_dst),
        .req_data  (req_data),
        .rdwn      (rdwn),
        .rdw       (rdw),
        .wrn       (wrn),
        .wr        (wr),
        .we        (we),
        .done      (done),
        .flag_h    (flag_h),
        .flag_c    (flag_c)
    );

    always #5 clk = ~clk;

    // Byte-wide regfile: index {pair,0} is the high byte, {pair,1} the low byte.
    logic [7:0] rf [8];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
        end else if (we) begin
            rf[wrn] <= wr;
        end
    end
    assign rdw = {rf[{rdwn, 1'b0}], rf[{rdwn, 1'b1}]};

    function automatic logic [15:0] pair(input logic [1:0] p);
        return {rf[{p, 1'b0}], rf[{p, 1'b1}]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one request from a post-edge slot; returns just after the accept edge.
    task automatic req_issue(input logic [1:0] op, input logic [1:0] src,
                             input logic [1:0] dst, input logic [15:0] data);
        int k;
        k = 0;
        @(posedge clk);
        #1;
        while (!req_ready && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("ready_before_accept", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_src   = src;
        req_dst   = dst;
        req_data  = data;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Follows the two write cycles and the done cycle of the request just accepted.
    task automatic check_writes(input string tag, input logic [1:0] dst, input logic [15:0] exp,
                                input logic h, input logic c);
        @(negedge clk);
        chk({tag, "_lo_we"},  {31'd0, we}, 32'd1);
        chk({tag, "_lo_wrn"}, {29'd0, wrn}, {29'd0, dst, 1'b1});
        chk({tag, "_lo_wr"},  {24'd0, wr}, {24'd0, exp[7:0]});
        chk({tag, "_lo_rdy"}, {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk({tag, "_hi_we"},  {31'd0, we}, 32'd1);
        chk({tag, "_hi_wrn"}, {29'd0, wrn}, {29'd0, dst, 1'b0});
        chk({tag, "_hi_wr"},  {24'd0, wr}, {24'd0, exp[15:8]});
        chk({tag, "_hi_rdy"}, {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk({tag, "_done"},   {31'd0, done}, 32'd1);
        chk({tag, "_idle_we"}, {31'd0, we}, 32'd0);
        chk({tag, "_h"},      {31'd0, flag_h}, {31'd0, h});
        chk({tag, "_c"},      {31'd0, flag_c}, {31'd0, c});
        chk({tag, "_pair"},   {16'd0, pair(dst)}, {16'd0, exp});
        @(negedge clk);
        chk({tag, "_done_off"}, {31'd0, done}, 32'd0);
        chk({tag, "_h_hold"},  {31'd0, flag_h}, {31'd0, h});
        chk({tag, "_c_hold"},  {31'd0, flag_c}, {31'd0, c});
    endtask

    int we_cnt;
    logic [5:0] we_pat, rdy_pat, done_pat;

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_op = LOAD;
        req_src = BC;
        req_dst = BC;
        req_data = 16'h0000;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_we",    {31'd0, we}, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_wrn",   {29'd0, wrn}, 32'd0);
        chk("rst_wr",    {24'd0, wr}, 32'd0);
        chk("rst_flags", {30'd0, flag_h, flag_c}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        rst = 1'b0;

        // LOAD DE,0x1234
        req_issue(LOAD, BC, DE, 16'h1234);
        check_writes("ld_de", DE, 16'h1234, 1'b0, 1'b0);

        // INC HL with HL=0xFFFF wraps to 0x0000 (src == dst)
        req_issue(LOAD, BC, HL, 16'hFFFF);
        check_writes("ld_hl", HL, 16'hFFFF, 1'b0, 1'b0);
        req_issue(INC, HL, HL, 16'h0000);
        check_writes("inc_hl", HL, 16'h0000, 1'b0, 1'b0);

        // DEC BC with BC=0x0000 wraps to 0xFFFF
        req_issue(DEC, BC, BC, 16'h0000);
        check_writes("dec_bc", BC, 16'hFFFF, 1'b0, 1'b0);

        // LD HL,SP+1 with SP=0x00FF: both carries set
        req_issue(LOAD, BC, SP, 16'h00FF);
        check_writes("ld_sp1", SP, 16'h00FF, 1'b0, 1'b0);
        req_issue(ADDS, SP, HL, 16'h0001);
        check_writes("adds_p1", HL, 16'h0100, 1'b1, 1'b1);

        // ADD SP,-1 with SP=0x1000: no carries; upper data byte is ignored
        req_issue(LOAD, BC, SP, 16'h1000);
        check_writes("ld_sp2", SP, 16'h1000, 1'b0, 1'b0);
        req_issue(ADDS, SP, SP, 16'hA5FF);
        check_writes("adds_m1", SP, 16'h0FFF, 1'b0, 1'b0);

        // req_valid held while busy with other data: ignored, dropped before done cycle
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_op = LOAD; req_dst = BC; req_data = 16'hAAAA;
        @(posedge clk);
        #1;
        req_data = 16'h5555; req_dst = DE;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("busy_done", {31'd0, done}, 32'd1);
        chk("busy_bc",   {16'd0, pair(BC)}, 32'h0000AAAA);
        chk("busy_de",   {16'd0, pair(DE)}, 32'h00001234);
        @(negedge clk);
        chk("busy_no_accept", {31'd0, we}, 32'd0);

        // Back-to-back: second request accepted in the done cycle of the first
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_op = LOAD; req_dst = DE; req_data = 16'h1111;
        @(posedge clk);
        #1;
        req_dst = HL; req_data = 16'h2222;
        we_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            we_pat[i]   = we;
            rdy_pat[i]  = req_ready;
            done_pat[i] = done;
            if (we) we_cnt++;
            @(posedge clk);
            if (i == 2) begin
                #1;
                req_valid = 1'b0;
            end
        end
        chk("b2b_we_cnt", we_cnt, 32'd4);
        chk("b2b_we_pat",   {26'd0, we_pat},   32'b011011);
        chk("b2b_rdy_pat",  {26'd0, rdy_pat},  32'b100100);
        chk("b2b_done_pat", {26'd0, done_pat}, 32'b100100);
        chk("b2b_de", {16'd0, pair(DE)}, 32'h00001111);
        chk("b2b_hl", {16'd0, pair(HL)}, 32'h00002222);

        // Async reset during WR_HI: enable drops at once, low byte stays updated
        req_issue(LOAD, BC, DE, 16'hBEEF);
        @(posedge clk);
        #2;
        chk("pre_rst_we", {31'd0, we}, 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_we",    {31'd0, we}, 32'd0);
        chk("arst_ready", {31'd0, req_ready}, 32'd1);
        chk("arst_done",  {31'd0, done}, 32'd0);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("arst_no_done", {31'd0, done}, 32'd0);
        chk("arst_we_off",  {31'd0, we}, 32'd0);
        chk("arst_de_half", {16'd0, pair(DE)}, 32'h000011EF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
